// File: rtl/execute_pkg.sv
// execute_pkg: shared definitions for the multi-cycle execute stage.
//   - OPW and the op_t operation-select type
//   - operation encodings (OP_UNKNOWN is 0, so an undriven select is harmless)
//   - op-class helpers used by the stage and its divider
package execute_pkg;

    localparam int OPW = 6;
    typedef logic [OPW-1:0] op_t;

    localparam op_t OP_UNKNOWN = 6'd0;
    // register-register ALU
    localparam op_t OP_ADD     = 6'd1;
    localparam op_t OP_SUB     = 6'd2;
    localparam op_t OP_SLL     = 6'd3;
    localparam op_t OP_SLT     = 6'd4;
    localparam op_t OP_SLTU    = 6'd5;
    localparam op_t OP_XOR     = 6'd6;
    localparam op_t OP_SRL     = 6'd7;
    localparam op_t OP_SRA     = 6'd8;
    localparam op_t OP_OR      = 6'd9;
    localparam op_t OP_AND     = 6'd10;
    // register-immediate ALU
    localparam op_t OP_ADDI    = 6'd11;
    localparam op_t OP_SLTI    = 6'd12;
    localparam op_t OP_SLTIU   = 6'd13;
    localparam op_t OP_XORI    = 6'd14;
    localparam op_t OP_ORI     = 6'd15;
    localparam op_t OP_ANDI    = 6'd16;
    localparam op_t OP_SLLI    = 6'd17;
    localparam op_t OP_SRLI    = 6'd18;
    localparam op_t OP_SRAI    = 6'd19;
    // upper immediates and memory address generation
    localparam op_t OP_LUI     = 6'd20;
    localparam op_t OP_AUIPC   = 6'd21;
    localparam op_t OP_LOAD    = 6'd22;
    localparam op_t OP_STORE   = 6'd23;
    // branches
    localparam op_t OP_BEQ     = 6'd24;
    localparam op_t OP_BNE     = 6'd25;
    localparam op_t OP_BLT     = 6'd26;
    localparam op_t OP_BGE     = 6'd27;
    localparam op_t OP_BLTU    = 6'd28;
    localparam op_t OP_BGEU    = 6'd29;
    // jumps
    localparam op_t OP_JAL     = 6'd30;
    localparam op_t OP_JALR    = 6'd31;
    // M extension
    localparam op_t OP_MUL     = 6'd32;
    localparam op_t OP_MULH    = 6'd33;
    localparam op_t OP_MULHSU  = 6'd34;
    localparam op_t OP_MULHU   = 6'd35;
    localparam op_t OP_DIV     = 6'd36;
    localparam op_t OP_DIVU    = 6'd37;
    localparam op_t OP_REM     = 6'd38;
    localparam op_t OP_REMU    = 6'd39;

    function automatic logic is_branch(op_t op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_jump(op_t op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic is_div(op_t op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // Stores, branches and unknown encodings never write the register file.
    function automatic logic writes_rd(op_t op);
        return ((op >= OP_ADD) && (op <= OP_LOAD)) || is_jump(op)
            || ((op >= OP_MUL) && (op <= OP_REMU));
    endfunction

    function automatic logic div_signed(op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic div_rem(op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/execute_mc_if.sv
// execute_mc_if: decode-side and memory-side handshakes of the execute stage.
//   master : the environment (drives operation, flush, downstream ready)
//   slave  : the execute stage (drives ready, result, flags, busy)
interface execute_mc_if #(
    parameter int N_param = 32
);
    import execute_pkg::*;

    // upstream operation
    logic               i_valid;
    logic               o_ready;
    op_t                i_op;
    logic [N_param-1:0] operand1_pi;
    logic [N_param-1:0] operand2_pi;
    logic [N_param-1:0] imm_i;
    logic [N_param-1:0] pc_i;
    logic [4:0]         rd_i;
    logic               i_flush;
    // downstream result
    logic               o_valid;
    logic               i_ready;
    logic [N_param-1:0] alu_result_1;
    logic [N_param-1:0] alu_result_2;
    logic [4:0]         rd_o;
    logic               branch_inst_wire;
    logic               jump_inst_wire;
    logic               write_reg_file_wire;
    logic               o_busy;

    modport master (
        output i_valid, i_op, operand1_pi, operand2_pi, imm_i, pc_i, rd_i,
               i_flush, i_ready,
        input  o_ready, o_valid, alu_result_1, alu_result_2, rd_o,
               branch_inst_wire, jump_inst_wire, write_reg_file_wire, o_busy
    );

    modport slave (
        input  i_valid, i_op, operand1_pi, operand2_pi, imm_i, pc_i, rd_i,
               i_flush, i_ready,
        output o_ready, o_valid, alu_result_1, alu_result_2, rd_o,
               branch_inst_wire, jump_inst_wire, write_reg_file_wire, o_busy
    );

endinterface

// File: rtl/execute_div_iter.sv
// execute_div_iter: iterative restoring divider, one quotient bit per cycle.
//   clk, srst  : clock, synchronous active-high reset
//   start      : latch operands and begin (ignored while iterating)
//   dividend,
//   divisor    : raw operands as presented by the stage
//   signed_op  : treat operands as two's complement
//   rem_sel    : return remainder instead of quotient
//   kill       : abandon the current division
//   done       : high in the cycle whose closing edge performs the last step
//   result     : final (sign-corrected) result, valid while done is high
// Magnitudes are divided unsigned and the sign is applied afterwards.
// Divide-by-zero yields an all-ones quotient and the dividend as remainder.
// Most-negative / -1 needs no special path: |dividend| / 1 gives the
// most-negative bit pattern back with a zero remainder.
module execute_div_iter #(
    parameter int N_param = 32
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    input  logic [N_param-1:0] dividend,
    input  logic [N_param-1:0] divisor,
    input  logic               signed_op,
    input  logic               rem_sel,
    input  logic               kill,
    output logic               done,
    output logic [N_param-1:0] result
);
    localparam int CW = $clog2(N_param);

    logic               busy_q, busy_d;
    logic [CW-1:0]      count_q, count_d;
    logic [N_param-1:0] rem_q, rem_d;
    logic [N_param-1:0] quo_q, quo_d;     // holds the remaining dividend bits, then the quotient
    logic [N_param-1:0] dvs_q, dvs_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               rem_sel_q, rem_sel_d;
    logic               div0_q, div0_d;

    logic [N_param-1:0] a_abs, b_abs;
    logic [N_param:0]   trial, diff;
    logic               fits;
    logic [N_param-1:0] rem_step, quo_step;
    logic [N_param-1:0] quo_fin, rem_fin;

    always_comb begin
        a_abs = (signed_op && dividend[N_param-1]) ? -dividend : dividend;
        b_abs = (signed_op && divisor[N_param-1])  ? -divisor  : divisor;

        // One restoring step: shift the next dividend bit into the partial
        // remainder and subtract the divisor if it fits (no borrow).
        trial    = {rem_q, quo_q[N_param-1]};
        diff     = trial - {1'b0, dvs_q};
        fits     = !diff[N_param];
        rem_step = fits ? diff[N_param-1:0] : trial[N_param-1:0];
        quo_step = {quo_q[N_param-2:0], fits};

        quo_fin = div0_q ? '1 : (quo_neg_q ? -quo_step : quo_step);
        rem_fin = rem_neg_q ? -rem_step : rem_step;
        result  = rem_sel_q ? rem_fin : quo_fin;
        done    = busy_q && (count_q == CW'(N_param - 1)) && !kill;

        busy_d    = busy_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        rem_sel_d = rem_sel_q;
        div0_d    = div0_q;

        if (kill) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            rem_d   = rem_step;
            quo_d   = quo_step;
            count_d = count_q + CW'(1);
            if (count_q == CW'(N_param - 1)) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            busy_d    = 1'b1;
            count_d   = '0;
            rem_d     = '0;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            div0_d    = (divisor == '0);
            quo_neg_d = signed_op && (dividend[N_param-1] ^ divisor[N_param-1]);
            rem_neg_d = signed_op && dividend[N_param-1];
            rem_sel_d = rem_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_q    <= 1'b0;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_sel_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            rem_sel_q <= rem_sel_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: rtl/execute_mc.sv
// execute_mc: registered multi-cycle execute stage (RV32I ALU/branch/jump + RV32M).
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : operation in (i_valid/o_ready, op, operands, imm, pc, rd),
//                  i_flush, result out (o_valid/i_ready, alu_result_1/2, rd_o,
//                  branch/jump/write flags), o_busy while the divider iterates.
// Everything except divide completes in one cycle; divides take N_param cycles.
module execute_mc
    import execute_pkg::*;
#(
    parameter int N_param = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    execute_mc_if.slave bus
);
    localparam int SHW = $clog2(N_param);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DIV  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic [N_param-1:0] res1_q, res1_d;
    logic [N_param-1:0] res2_q, res2_d;
    logic [4:0]         rd_q, rd_d;
    logic               br_q, br_d;     // branch taken (already qualified by is_branch)
    logic               jmp_q, jmp_d;
    logic               wr_q, wr_d;     // op class writes rd; rd!=0 is applied at the output

    logic               ready;
    logic               accept;
    logic               div_start;
    logic               div_done;
    logic [N_param-1:0] div_result;

    // ---------------- single-cycle datapath ----------------
    logic [N_param-1:0]   a, b, imm, pc;
    logic [SHW-1:0]       sh_r, sh_i;
    logic [N_param-1:0]   sum_ri, pc_imm, pc_4, jalr_t;
    logic [2*N_param-1:0] mul_a, mul_b, prod;
    logic [N_param-1:0]   res1_c, res2_c;
    logic                 cond_c;

    assign a      = bus.operand1_pi;
    assign b      = bus.operand2_pi;
    assign imm    = bus.imm_i;
    assign pc     = bus.pc_i;
    assign sh_r   = b[SHW-1:0];
    assign sh_i   = imm[SHW-1:0];
    assign sum_ri = a + imm;
    assign pc_imm = pc + imm;
    assign pc_4   = pc + N_param'(4);

    always_comb begin
        // Extend each multiplier operand to 2N bits according to its
        // signedness so one unsigned multiplier serves all four variants.
        mul_a = {{N_param{((bus.i_op == OP_MULH) || (bus.i_op == OP_MULHSU)) && a[N_param-1]}}, a};
        mul_b = {{N_param{(bus.i_op == OP_MULH) && b[N_param-1]}}, b};
        prod  = mul_a * mul_b;

        jalr_t    = sum_ri;
        jalr_t[0] = 1'b0;

        res1_c = '0;
        res2_c = '0;
        cond_c = 1'b0;
        case (bus.i_op)
            OP_ADD:    res1_c = a + b;
            OP_SUB:    res1_c = a - b;
            OP_SLL:    res1_c = a << sh_r;
            OP_SLT:    res1_c[0] = $signed(a) < $signed(b);
            OP_SLTU:   res1_c[0] = a < b;
            OP_XOR:    res1_c = a ^ b;
            OP_SRL:    res1_c = a >> sh_r;
            OP_SRA:    res1_c = $signed(a) >>> sh_r;
            OP_OR:     res1_c = a | b;
            OP_AND:    res1_c = a & b;
            OP_ADDI:   res1_c = sum_ri;
            OP_SLTI:   res1_c[0] = $signed(a) < $signed(imm);
            OP_SLTIU:  res1_c[0] = a < imm;
            OP_XORI:   res1_c = a ^ imm;
            OP_ORI:    res1_c = a | imm;
            OP_ANDI:   res1_c = a & imm;
            OP_SLLI:   res1_c = a << sh_i;
            OP_SRLI:   res1_c = a >> sh_i;
            OP_SRAI:   res1_c = $signed(a) >>> sh_i;
            OP_LUI:    res1_c = imm;
            OP_AUIPC:  res1_c = pc_imm;
            OP_LOAD,
            OP_STORE:  res1_c = sum_ri;
            OP_BEQ:    cond_c = (a == b);
            OP_BNE:    cond_c = (a != b);
            OP_BLT:    cond_c = $signed(a) < $signed(b);
            OP_BGE:    cond_c = $signed(a) >= $signed(b);
            OP_BLTU:   cond_c = a < b;
            OP_BGEU:   cond_c = a >= b;
            OP_JAL: begin
                res1_c = pc_4;
                res2_c = pc_imm;
            end
            OP_JALR: begin
                res1_c = pc_4;
                res2_c = jalr_t;
            end
            OP_MUL:    res1_c = prod[N_param-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  res1_c = prod[2*N_param-1:N_param];
            default: ;
        endcase
        if (is_branch(bus.i_op)) begin
            res1_c[0] = cond_c;
            res2_c    = pc_imm;
        end
    end

    // ---------------- divider ----------------
    assign div_start = accept && is_div(bus.i_op) && !bus.i_flush;

    execute_div_iter #(
        .N_param (N_param)
    ) u_div (
        .clk       (i_clk),
        .srst      (i_rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .signed_op (div_signed(bus.i_op)),
        .rem_sel   (div_rem(bus.i_op)),
        .kill      (bus.i_flush),
        .done      (div_done),
        .result    (div_result)
    );

    // ---------------- control ----------------
    assign ready  = (state_q == ST_IDLE) && (!valid_q || bus.i_ready);
    assign accept = bus.i_valid && ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        rd_d    = rd_q;
        br_d    = br_q;
        jmp_d   = jmp_q;
        wr_d    = wr_q;

        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        if (bus.i_flush) begin
            // Flush wins over accept, completion and handoff.
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (state_q == ST_DIV) begin
            if (div_done) begin
                state_d = ST_IDLE;
                valid_d = 1'b1;
                res1_d  = div_result;
            end
        end else if (accept) begin
            rd_d  = bus.rd_i;
            wr_d  = writes_rd(bus.i_op);
            jmp_d = is_jump(bus.i_op);
            if (is_div(bus.i_op)) begin
                state_d = ST_DIV;
                valid_d = 1'b0;
                res1_d  = '0;
                res2_d  = '0;
                br_d    = 1'b0;
            end else begin
                valid_d = 1'b1;
                res1_d  = res1_c;
                res2_d  = res2_c;
                br_d    = is_branch(bus.i_op) && cond_c;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            res1_q  <= '0;
            res2_q  <= '0;
            rd_q    <= '0;
            br_q    <= 1'b0;
            jmp_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            rd_q    <= rd_d;
            br_q    <= br_d;
            jmp_q   <= jmp_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.o_ready             = ready;
    assign bus.o_valid             = valid_q;
    assign bus.alu_result_1        = res1_q;
    assign bus.alu_result_2        = res2_q;
    assign bus.rd_o                = rd_q;
    assign bus.branch_inst_wire    = valid_q && br_q;
    assign bus.jump_inst_wire      = valid_q && jmp_q;
    assign bus.write_reg_file_wire = valid_q && wr_q && (rd_q != 5'd0);
    assign bus.o_busy              = (state_q == ST_DIV);

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: scoreboard bench for execute_mc. Expected results are
// pushed when an operation is driven and compared at each result handoff.
module tb_execute_mc;
    import execute_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_mc_if #(.N_param(N)) bus ();

    execute_mc #(.N_param(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        br;
        logic        jmp;
        logic        wr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Independent reference model of one operation.
    function automatic exp_t model(op_t op, logic [31:0] a, logic [31:0] b,
                                   logic [31:0] imm, logic [31:0] pc, logic [4:0] rd);
        exp_t        e;
        int          sa, sb, si;
        longint      pa, pb;
        logic [63:0] p;
        logic        w, c;
        sa = $signed(a); sb = $signed(b); si = $signed(imm);
        e.r1 = 32'h0; e.r2 = 32'h0; e.rd = rd; e.br = 1'b0; e.jmp = 1'b0;
        w = 1'b1; c = 1'b0; pa = 0; pb = 0;
        case (op)
            OP_ADD:   e.r1 = a + b;
            OP_SUB:   e.r1 = a - b;
            OP_SLL:   e.r1 = a << b[4:0];
            OP_SLT:   e.r1 = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  e.r1 = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:   e.r1 = a ^ b;
            OP_SRL:   e.r1 = a >> b[4:0];
            OP_SRA:   e.r1 = sa >>> b[4:0];
            OP_OR:    e.r1 = a | b;
            OP_AND:   e.r1 = a & b;
            OP_ADDI:  e.r1 = a + imm;
            OP_SLTI:  e.r1 = (sa < si) ? 32'd1 : 32'd0;
            OP_SLTIU: e.r1 = (a < imm) ? 32'd1 : 32'd0;
            OP_XORI:  e.r1 = a ^ imm;
            OP_ORI:   e.r1 = a | imm;
            OP_ANDI:  e.r1 = a & imm;
            OP_SLLI:  e.r1 = a << imm[4:0];
            OP_SRLI:  e.r1 = a >> imm[4:0];
            OP_SRAI:  e.r1 = sa >>> imm[4:0];
            OP_LUI:   e.r1 = imm;
            OP_AUIPC: e.r1 = pc + imm;
            OP_LOAD:  e.r1 = a + imm;
            OP_STORE: begin e.r1 = a + imm; w = 1'b0; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  c = (a == b);
                    OP_BNE:  c = (a != b);
                    OP_BLT:  c = (sa < sb);
                    OP_BGE:  c = (sa >= sb);
                    OP_BLTU: c = (a < b);
                    default: c = (a >= b);
                endcase
                e.r1 = {31'b0, c}; e.r2 = pc + imm; e.br = c; w = 1'b0;
            end
            OP_JAL:   begin e.r1 = pc + 32'd4; e.r2 = pc + imm; e.jmp = 1'b1; end
            OP_JALR:  begin e.r1 = pc + 32'd4; e.r2 = (a + imm) & 32'hFFFF_FFFE; e.jmp = 1'b1; end
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                pa = (op == OP_MULHU) ? longint'({32'h0, a}) : longint'(sa);
                pb = (op == OP_MULH)  ? longint'(sb) : longint'({32'h0, b});
                if (op == OP_MUL) pb = longint'(sb);
                p = pa * pb;
                e.r1 = (op == OP_MUL) ? p[31:0] : p[63:32];
            end
            OP_DIV: begin
                if (b == 0) e.r1 = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.r1 = 32'h8000_0000;
                else e.r1 = sa / sb;
            end
            OP_REM: begin
                if (b == 0) e.r1 = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.r1 = 32'h0;
                else e.r1 = sa % sb;
            end
            OP_DIVU:  e.r1 = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:  e.r1 = (b == 0) ? a : a % b;
            default:  w = 1'b0;
        endcase
        e.wr = w && (rd != 5'd0);
        return e;
    endfunction

    // Scoreboard monitor: compare at every handoff (not during flush/reset).
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.o_valid && bus.i_ready && !bus.i_flush) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("[%0t] txn res1=%08h res2=%08h rd=%0d br=%0b jmp=%0b wr=%0b",
                         $time, bus.alu_result_1, bus.alu_result_2, bus.rd_o,
                         bus.branch_inst_wire, bus.jump_inst_wire, bus.write_reg_file_wire);
                check("res1", bus.alu_result_1, e.r1);
                check("res2", bus.alu_result_2, e.r2);
                check("rd_o", 32'(bus.rd_o), 32'(e.rd));
                check("flags", {29'b0, bus.branch_inst_wire, bus.jump_inst_wire, bus.write_reg_file_wire},
                      {29'b0, e.br, e.jmp, e.wr});
            end
        end
    end

    task automatic set_inputs(input op_t op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        bus.i_valid = 1'b1; bus.i_op = op; bus.operand1_pi = a; bus.operand2_pi = b;
        bus.imm_i = imm; bus.pc_i = pc; bus.rd_i = rd;
    endtask

    task automatic drive(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        set_inputs(op, a, b, imm, pc, rd);
        sb_q.push_back(model(op, a, b, imm, pc, rd));
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.o_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        drive(op, a, b, imm, pc, rd);
        wait_accept();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Start a divide, run 10 iterations and return while it is still busy.
    task automatic start_div_run10();
        issue(OP_DIV, 32'd1000, 32'd7, 32'd0, 32'd0, 5'd9);
        repeat (10) @(posedge clk);
        #1;
        check("mid_div_busy", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic check_killed(input string tag);
        int vcount;
        check({tag, "_busy"},  32'(bus.o_busy),  32'd0);
        check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid) vcount++;
        end
        check({tag, "_no_result"}, 32'(vcount), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        op_t op;
        logic [31:0] ra, rb;

        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_op = OP_UNKNOWN; bus.operand1_pi = '0; bus.operand2_pi = '0;
        bus.imm_i = '0; bus.pc_i = '0; bus.rd_i = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_busy",  32'(bus.o_busy),  32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_res1",  bus.alu_result_1, 32'd0);
        check("rst_res2",  bus.alu_result_2, 32'd0);
        check("rst_flags", {27'b0, bus.rd_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD overflow wrap, with and without a real destination
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5);
        check("add_lat1_valid", 32'(bus.o_valid), 32'd1);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0);
        wait_drain();

        // Four back-to-back ADDIs at full throughput
        c0 = cyc;
        for (int i = 0; i < 4; i++) issue(OP_ADDI, 32'(i * 100), 32'd0, 32'(i + 1), 32'd0, 5'(i + 1));
        check("burst_cycles", 32'(cyc - c0), 32'd4);
        wait_drain();

        // Hold: downstream stalls for several cycles with another op pending
        bus.i_ready = 1'b0;
        issue(OP_ADDI, 32'd10, 32'd0, 32'd5, 32'd0, 5'd3);
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4);
        repeat (3) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_ready", 32'(bus.o_ready), 32'd0);
            check("hold_res1",  bus.alu_result_1, 32'd15);
        end
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        wait_accept();
        wait_drain();

        // Divide latency
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd6);
        check("div_busy",  32'(bus.o_busy),  32'd1);
        check("div_ready", 32'(bus.o_ready), 32'd0);
        n = 0;
        while (1) begin
            @(posedge clk); n++; #1;
            if (bus.o_valid || n > 100) break;
        end
        check("div_latency", 32'(n), 32'd32);
        wait_drain();

        // Divide corner cases
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2,          32'd0, 32'd0, 5'd7);
        issue(OP_DIVU, 32'd5,         32'd0,          32'd0, 32'd0, 5'd8);
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd0,          32'd0, 32'd0, 5'd8);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd0,          32'd0, 32'd0, 5'd8);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0, 32'd0, 5'd9);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0, 32'd0, 5'd10);
        wait_drain();

        // Branches, jumps, multiplies and misc
        issue(OP_BLT,    32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd1);
        issue(OP_BLTU,   32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd1);
        issue(OP_BGE,    32'd3,         32'd3, 32'hFFFF_FFF0, 32'h200, 5'd2);
        issue(OP_JALR,   32'h203,       32'd0, 32'd0,  32'h400, 5'd1);
        issue(OP_JAL,    32'd0,         32'd0, 32'h40, 32'h500, 5'd1);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd11);
        issue(OP_MULH,   32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0, 5'd12);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd13);
        issue(OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 5'd14);
        issue(OP_SRA,    32'h8000_0000, 32'd35, 32'd0, 32'd0, 5'd15);
        issue(OP_SLTIU,  32'd3, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd16);
        issue(OP_STORE,  32'h1000, 32'd0, 32'd8, 32'd0, 5'd17);
        issue(OP_UNKNOWN, 32'hDEAD_BEEF, 32'd1, 32'd2, 32'd3, 5'd18);
        wait_drain();

        // Flush mid-divide; a simultaneously presented op is dropped
        start_div_run10();
        set_inputs(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0;
        void'(sb_q.pop_back());
        check_killed("flush_div");

        // Flush beats an accept in IDLE
        set_inputs(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 5'd2);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0;
        @(negedge clk);
        check("flush_drop_valid", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;

        // A result presented during flush is not consumed
        bus.i_ready = 1'b0;
        issue(OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 5'd3);
        bus.i_ready = 1'b1; bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        void'(sb_q.pop_back());
        check("flush_out_valid", 32'(bus.o_valid), 32'd0);

        // Reset mid-divide
        start_div_run10();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("rst_div_res1", bus.alu_result_1, 32'd0);
        check_killed("rst_div");

        // Random mix including divides and unknown encodings
        for (int i = 0; i < 40; i++) begin
            op = op_t'($urandom_range(0, 45));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            issue(op, ra, rb, $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised, registered successor to the single-cycle execute stage.
- Executes the RV32I ALU, branch and jump subset plus RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Multiply completes in 1 cycle; divide is iterative, one quotient bit per cycle.
- Sits between decode and memory stages with a valid/ready handshake on both sides and a flush input for branch redirects.

Parameters:
- N_param, 32, datapath width (XLEN); must be a power of two, ≥8.
- SHW, $clog2(N_param), shift-amount width; derived, not overridable.
- OPW, 6, width of the encoded operation select.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream operation valid.
- o_ready  out  1  stage can accept an operation this cycle.
- i_op  in  OPW  encoded operation, from the package.
- operand1_pi  in  N_param  rs1 data.
- operand2_pi  in  N_param  rs2 data.
- imm_i  in  N_param  sign-extended immediate.
- pc_i  in  N_param  instruction PC.
- rd_i  in  5  destination register.
- i_flush  in  1  kill in-flight and pending output.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- alu_result_1  out  N_param  primary result / branch condition in bit 0.
- alu_result_2  out  N_param  branch/jump target.
- rd_o  out  5  registered rd.
- branch_inst_wire  out  1  taken branch.
- jump_inst_wire  out  1  jump.
- write_reg_file_wire  out  1  register write enable.
- o_busy  out  1  divider iterating.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - state=IDLE, o_valid=0, all result/flag registers 0, o_busy=0.
  - Reset overrides flush and accept, including mid-divide.
- States: IDLE, DIV. o_ready = (state==IDLE) && (!o_valid || i_ready).
- Accept: i_valid && o_ready at a rising edge.
- Single-cycle ops:
  - Result, flags and rd_o are registered at the accept edge, and o_valid=1 afterwards. Latency is 1.
  - Back-to-back accepts are allowed when i_ready=1 (full throughput).
- Hold: if o_valid && !i_ready, all outputs hold stable and o_ready=0.
- Divide ops:
  - The accept edge latches |dividend| and |divisor|, the result sign and the op, and moves to DIV with count=0.
  - Each DIV edge performs one restoring step. On count==N_param-1 the result is written, o_valid=1 and state returns to IDLE. Latency is N_param cycles.
  - o_busy=1 while in DIV; o_ready=0 while in DIV.
- Divide corner cases (RISC-V defined, no trap):
  - Divide by zero: quotient = all ones; remainder = dividend. Both complete with normal latency.
  - Signed overflow (most-negative ÷ -1): quotient = most-negative; remainder = 0.
- Multiply:
  - Full 2N_param-bit product.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Arithmetic and compare rules:
  - Shifts use operand[SHW-1:0] or imm[SHW-1:0].
  - SLT/SLTI/BLT/BGE compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned.
  - Add and sub wrap modulo 2^N_param.
- Branches: alu_result_1 = {0…, cond}; alu_result_2 = pc_i+imm_i; branch_inst_wire = o_valid & is_branch & cond.
- Jumps:
  - JAL: alu_result_1 = pc_i+4; alu_result_2 = pc_i+imm_i; jump_inst_wire = o_valid.
  - JALR: alu_result_1 = pc_i+4; alu_result_2 = (rs1+imm)&~1; jump_inst_wire = o_valid.
- Register write: write_reg_file_wire = o_valid & writes_rd & (rd_o!=0). Stores and branches never write.
- Unknown op: accepted; o_valid=1; all results and flags 0; no write.
- Flush (i_flush=1):
  - Next state is IDLE with o_valid=0.
  - Aborts an iterating divide.
  - Flush beats a simultaneous accept: the incoming op is dropped.
  - A result presented the same cycle as flush is not consumed.
- Simultaneous events:
  - Handing off a result (o_valid && i_ready) while accepting a new op in the same cycle is legal; the new result replaces the old.
  - The divider completing while the previous result is still stalled cannot occur, because a divide is only accepted when o_ready=1.

Decomposition:
- Package execute_pkg holds:
  - the OPW-wide op encodings (OP_ADD … OP_REMU, OP_UNKNOWN=0);
  - op-class helper functions (is_branch, is_jump, writes_rd, is_div).
- One sub-module: execute_div_iter, the N_param-parametrised restoring divider.
  - Ports: start, dividend, divisor, signed_op, rem_sel, kill, done, result.
  - Sign fix-up and the divide-by-zero and overflow cases live inside it.

Test Plan:
- ADD 0x7FFFFFFF + 1, i_ready=1 → next cycle o_valid=1, alu_result_1=0x80000000, write_reg_file_wire=1 (rd=5); with rd=0 → write_reg_file_wire=0.
- Throughput and hold:
  - 4 back-to-back ADDIs with i_ready=1 → 4 consecutive valid results.
  - Drop i_ready for 3 cycles → outputs stable, o_ready=0, no op lost.
- DIV -7/2 → after exactly 32 cycles quotient 0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF; REM 0x80000000/-1 → 0; DIV 0x80000000/-1 → 0x80000000.
- Branch and jump targets:
  - BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → branch_inst_wire=1, alu_result_2=0x120.
  - BLTU with the same operands → branch_inst_wire=0.
  - JALR rs1=0x203, imm=0 → alu_result_2=0x202, alu_result_1=pc+4.
- Kill cases:
  - Start DIV, assert i_flush at iteration 10 → o_valid never rises, o_busy=0 next cycle, o_ready=1.
  - i_rst mid-divide → same response.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
